// File: rtl/toy_prealloc_queue_pkg.sv
// Shared definitions for the decode-side physical-register pre-allocation queue.
package toy_prealloc_queue_pkg;

   localparam int INST_DECODE_NUM  = 4;
   localparam int PHY_REG_ID_WIDTH = 7;

   typedef logic [PHY_REG_ID_WIDTH-1:0] phy_id_t;

endpackage : toy_prealloc_queue_pkg

// File: rtl/toy_prealloc_queue_prefix_count.sv
// Lane-ordered inclusive prefix popcount: incl_cnt[i] = number of set bits in lane_bits[i:0].
// The exclusive rank of a set lane is incl_cnt[i]-1.
module toy_prefix_count #(
   parameter int N  = 4,
   parameter int CW = $clog2(N + 1)
) (
   input  logic [N-1:0]         lane_bits,
   output logic [N-1:0][CW-1:0] incl_cnt
);
   import toy_prealloc_queue_pkg::*;

   logic [CW-1:0] acc_s;

   // Running sum over lanes in ascending lane order.
   always_comb begin
      acc_s    = '0;
      incl_cnt = '0;
      for (int i = 0; i < N; i++) begin
         acc_s       = acc_s + CW'(lane_bits[i]);
         incl_cnt[i] = acc_s;
      end
   end

endmodule : toy_prefix_count

// File: rtl/toy_prealloc_queue.sv
// Free physical-register ID pre-allocation queue between the free list and decode/rename.
// Optional feature macro: TOY_PREALLOC_BYPASS_EN lets IDs accepted this cycle serve
// requests in the same cycle once the queued entries are exhausted.
module toy_prealloc_queue #(
   parameter int INST_DECODE_NUM  = toy_prealloc_queue_pkg::INST_DECODE_NUM,
   parameter int PHY_REG_ID_WIDTH = toy_prealloc_queue_pkg::PHY_REG_ID_WIDTH,
   parameter int DEPTH            = 8
) (
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic [INST_DECODE_NUM-1:0]                  fl_vld,
   input  logic [PHY_REG_ID_WIDTH*INST_DECODE_NUM-1:0] fl_id,
   output logic [INST_DECODE_NUM-1:0]                  fl_rdy,
   input  logic [INST_DECODE_NUM-1:0]                  dec_vld,
   input  logic [INST_DECODE_NUM-1:0]                  dec_rd_en,
   output logic                                        dec_rdy,
   output logic [PHY_REG_ID_WIDTH*INST_DECODE_NUM-1:0] dec_alloc_id,
   input  logic                                        cancel_edge_en,
   output logic [$clog2(DEPTH):0]                      q_count
);
   import toy_prealloc_queue_pkg::*;

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int LN_W  = $clog2(INST_DECODE_NUM + 1);
   localparam int SUM_W = CNT_W + 1;
   localparam int IW    = PHY_REG_ID_WIDTH;

   // Registered queue state
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic [IW-1:0]    mem_r [DEPTH];

   // Lane rank vectors
   logic [INST_DECODE_NUM-1:0][LN_W-1:0] vld_incl_s;
   logic [INST_DECODE_NUM-1:0][LN_W-1:0] rdy_incl_s;
   logic [INST_DECODE_NUM-1:0][LN_W-1:0] req_incl_s;

   logic [INST_DECODE_NUM-1:0] fl_rdy_s;
   logic [INST_DECODE_NUM-1:0] req_s;
   logic                       dec_rdy_s;
   logic [CNT_W-1:0]           free_s;
   logic [CNT_W-1:0]           push_num_s;
   logic [CNT_W-1:0]           need_s;
   logic [CNT_W-1:0]           byp_num_s;
   logic [CNT_W-1:0]           q_push_s;
   logic [CNT_W-1:0]           q_pop_s;
   logic [SUM_W-1:0]           avail_s;
   logic [CNT_W-1:0]           pos_s;
`ifdef TOY_PREALLOC_BYPASS_EN
   logic                       hit_s;
`endif

   logic [INST_DECODE_NUM-1:0]             wr_en_s;
   logic [INST_DECODE_NUM-1:0][PTR_W-1:0]  wr_idx_s;
   logic [IW*INST_DECODE_NUM-1:0]          dec_alloc_id_s;

   assign req_s = dec_vld & dec_rd_en;

   toy_prefix_count #(.N(INST_DECODE_NUM), .CW(LN_W)) u_vld_rank (
      .lane_bits (fl_vld),
      .incl_cnt  (vld_incl_s)
   );

   toy_prefix_count #(.N(INST_DECODE_NUM), .CW(LN_W)) u_rdy_rank (
      .lane_bits (fl_rdy_s),
      .incl_cnt  (rdy_incl_s)
   );

   toy_prefix_count #(.N(INST_DECODE_NUM), .CW(LN_W)) u_req_rank (
      .lane_bits (req_s),
      .incl_cnt  (req_incl_s)
   );

   // Accept an offered lane only while its lane-ordered offer rank fits in the registered free space.
   always_comb begin
      free_s = CNT_W'(DEPTH) - count_r;
      for (int i = 0; i < INST_DECODE_NUM; i++) begin
         if (rst) begin
            fl_rdy_s[i] = 1'b0;
         end else begin
            fl_rdy_s[i] = fl_vld[i] & (CNT_W'(vld_incl_s[i]) <= free_s);
         end
      end
   end

   // Group grant plus the split of the serviced IDs between queued and bypassed sources.
   always_comb begin
      need_s     = CNT_W'(req_incl_s[INST_DECODE_NUM-1]);
      push_num_s = CNT_W'(rdy_incl_s[INST_DECODE_NUM-1]);
`ifdef TOY_PREALLOC_BYPASS_EN
      avail_s    = SUM_W'(count_r) + SUM_W'(push_num_s);
`else
      avail_s    = SUM_W'(count_r);
`endif
      if (rst) begin
         dec_rdy_s = 1'b0;
      end else begin
         dec_rdy_s = (|dec_vld) & ~cancel_edge_en & (SUM_W'(need_s) <= avail_s);
      end
`ifdef TOY_PREALLOC_BYPASS_EN
      if (dec_rdy_s && (need_s > count_r)) begin
         byp_num_s = need_s - count_r;
      end else begin
         byp_num_s = '0;
      end
`else
      byp_num_s = '0;
`endif
      if (dec_rdy_s) begin
         q_pop_s = need_s - byp_num_s;
      end else begin
         q_pop_s = '0;
      end
      q_push_s = push_num_s - byp_num_s;
   end

   // Accepted lanes not consumed by bypass land in consecutive slots starting at wr_ptr.
   always_comb begin
      for (int i = 0; i < INST_DECODE_NUM; i++) begin
         wr_en_s[i]  = fl_rdy_s[i] & (CNT_W'(rdy_incl_s[i]) > byp_num_s);
         wr_idx_s[i] = wr_ptr_r +
                       PTR_W'(CNT_W'(rdy_incl_s[i]) - byp_num_s - CNT_W'(1'b1));
      end
   end

   // The k-th requesting lane receives the k-th oldest available ID; other lanes read zero.
   always_comb begin
      dec_alloc_id_s = '0;
      pos_s          = '0;
`ifdef TOY_PREALLOC_BYPASS_EN
      hit_s          = 1'b0;
`endif
      for (int i = 0; i < INST_DECODE_NUM; i++) begin
         pos_s = CNT_W'(req_incl_s[i]) - CNT_W'(1'b1);
         if (req_s[i]) begin
`ifdef TOY_PREALLOC_BYPASS_EN
            if (pos_s < count_r) begin
               dec_alloc_id_s[i*IW +: IW] = mem_r[rd_ptr_r + PTR_W'(pos_s)];
            end else begin
               for (int j = 0; j < INST_DECODE_NUM; j++) begin
                  hit_s = fl_rdy_s[j] &
                          ((CNT_W'(rdy_incl_s[j]) - CNT_W'(1'b1)) == (pos_s - count_r));
                  dec_alloc_id_s[i*IW +: IW] = dec_alloc_id_s[i*IW +: IW] |
                                               ({IW{hit_s}} & fl_id[j*IW +: IW]);
               end
            end
`else
            dec_alloc_id_s[i*IW +: IW] = mem_r[rd_ptr_r + PTR_W'(pos_s)];
`endif
         end else begin
            dec_alloc_id_s[i*IW +: IW] = '0;
         end
      end
   end

   // Pointer and occupancy update; reset discards every queued ID.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         wr_ptr_r <= wr_ptr_r + PTR_W'(q_push_s);
         rd_ptr_r <= rd_ptr_r + PTR_W'(q_pop_s);
         count_r  <= count_r + q_push_s - q_pop_s;
      end
   end

   // ID storage; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < INST_DECODE_NUM; i++) begin
         if (wr_en_s[i]) begin
            mem_r[wr_idx_s[i]] <= fl_id[i*IW +: IW];
         end
      end
   end

   assign fl_rdy       = fl_rdy_s;
   assign dec_rdy      = dec_rdy_s;
   assign dec_alloc_id = dec_alloc_id_s;
   assign q_count      = count_r;

endmodule : toy_prealloc_queue

// File: tb/tb_toy_prealloc_queue.sv
// Randomized bench for toy_prealloc_queue against a queue-of-IDs reference model.
module tb_toy_prealloc_queue;
   import toy_prealloc_queue_pkg::*;

   localparam int N     = 4;
   localparam int W     = 7;
   localparam int DEPTH = 8;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   fl_vld;
   logic [N*W-1:0] fl_id;
   logic [N-1:0]   fl_rdy;
   logic [N-1:0]   dec_vld;
   logic [N-1:0]   dec_rd_en;
   logic           dec_rdy;
   logic [N*W-1:0] dec_alloc_id;
   logic           cancel_edge_en;
   logic [3:0]     q_count;

   int checks_cnt = 0;
   int errors_cnt = 0;

   phy_id_t        ref_q[$];
   logic [N-1:0]   obs_fl_rdy;
   logic           obs_dec_rdy;
   logic [N*W-1:0] obs_ids;
   int             seq_id = 40;

   toy_prealloc_queue #(.INST_DECODE_NUM(N), .PHY_REG_ID_WIDTH(W), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst            (rst),
      .fl_vld         (fl_vld),
      .fl_id          (fl_id),
      .fl_rdy         (fl_rdy),
      .dec_vld        (dec_vld),
      .dec_rd_en      (dec_rd_en),
      .dec_rdy        (dec_rdy),
      .dec_alloc_id   (dec_alloc_id),
      .cancel_edge_en (cancel_edge_en),
      .q_count        (q_count)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks_cnt++;
      if (obs !== exp) begin
         errors_cnt++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [N*W-1:0] pack4(input int a, input int b, input int c, input int d);
      return {W'(d), W'(c), W'(b), W'(a)};
   endfunction

   // One clock: drive at negedge, check combinational outputs, check occupancy after the edge.
   task automatic run_cycle(input logic r, input logic [N-1:0] fv, input logic [N*W-1:0] fid,
                            input logic [N-1:0] dv, input logic [N-1:0] de, input logic cc);
      int      free_n, vcnt, acc_n, need, avail, k;
      logic [N-1:0] exp_rdy;
      logic    exp_dec;
      phy_id_t src[$];
      phy_id_t lane_id;
      @(negedge clk);
      rst = r; fl_vld = fv; fl_id = fid; dec_vld = dv; dec_rd_en = de; cancel_edge_en = cc;
      #1;
      free_n  = DEPTH - ref_q.size();
      exp_rdy = '0;
      vcnt    = 0;
      acc_n   = 0;
      src     = ref_q;
      for (int i = 0; i < N; i++) begin
         if (fv[i]) begin
            vcnt++;
            if (!r && vcnt <= free_n) begin
               exp_rdy[i] = 1'b1;
               acc_n++;
               lane_id = fid[i*W +: W];
               src.push_back(lane_id);
            end
         end
      end
      need = 0;
      for (int i = 0; i < N; i++) need += int'(dv[i] & de[i]);
`ifdef TOY_PREALLOC_BYPASS_EN
      avail = ref_q.size() + acc_n;
`else
      avail = ref_q.size();
`endif
      exp_dec = !r && (dv != '0) && !cc && (need <= avail);
      check_val("fl_rdy", 32'(fl_rdy), 32'(exp_rdy));
      check_val("dec_rdy", 32'(dec_rdy), 32'(exp_dec));
      k = 0;
      for (int i = 0; i < N; i++) begin
         lane_id = dec_alloc_id[i*W +: W];
         if (dv[i] && de[i]) begin
            if (exp_dec) check_val("alloc_id", 32'(lane_id), 32'(src[k]));
            k++;
         end else begin
            check_val("idle_lane_zero", 32'(lane_id), 32'd0);
         end
      end
      obs_fl_rdy  = fl_rdy;
      obs_dec_rdy = dec_rdy;
      obs_ids     = dec_alloc_id;
      @(posedge clk);
      #1;
      if (r) begin
         ref_q.delete();
      end else begin
         if (exp_dec) begin
            for (int i = 0; i < need; i++) void'(src.pop_front());
         end
         ref_q = src;
      end
      check_val("q_count", 32'(q_count), 32'(ref_q.size()));
   endtask

   function automatic int lane_of(input logic [N*W-1:0] ids, input int lane);
      logic [W-1:0] v;
      v = ids[lane*W +: W];
      return int'(v);
   endfunction

   initial begin
      rst = 1'b1; fl_vld = '0; fl_id = '0; dec_vld = '0; dec_rd_en = '0; cancel_edge_en = 1'b0;

      // Reset held two cycles with all lanes offering
      run_cycle(1'b1, 4'hF, pack4(1, 2, 3, 4), 4'h0, 4'h0, 1'b0);
      check_val("rst_fl_rdy", 32'(obs_fl_rdy), 32'h0);
      run_cycle(1'b1, 4'hF, pack4(1, 2, 3, 4), 4'h0, 4'h0, 1'b0);
      check_val("rst_q_count", 32'(q_count), 32'd0);

      // Fill to full
      run_cycle(1'b0, 4'hF, pack4(10, 11, 12, 13), 4'h0, 4'h0, 1'b0);
      check_val("fill1_rdy", 32'(obs_fl_rdy), 32'hF);
      check_val("fill1_cnt", 32'(q_count), 32'd4);
      run_cycle(1'b0, 4'hF, pack4(14, 15, 16, 17), 4'h0, 4'h0, 1'b0);
      check_val("fill2_cnt", 32'(q_count), 32'd8);
      run_cycle(1'b0, 4'hF, pack4(18, 19, 20, 21), 4'h0, 4'h0, 1'b0);
      check_val("full_rdy", 32'(obs_fl_rdy), 32'h0);
      check_val("full_cnt", 32'(q_count), 32'd8);

      // Pop two, then partial accept at count 6
      run_cycle(1'b0, 4'h0, '0, 4'h3, 4'h3, 1'b0);
      check_val("pop2_id0", 32'(lane_of(obs_ids, 0)), 32'd10);
      check_val("pop2_id1", 32'(lane_of(obs_ids, 1)), 32'd11);
      run_cycle(1'b0, 4'hF, pack4(30, 31, 32, 33), 4'h0, 4'h0, 1'b0);
      check_val("partial_rdy", 32'(obs_fl_rdy), 32'h3);
      check_val("partial_cnt", 32'(q_count), 32'd8);

      // Compaction from a fresh queue holding 10,11,12
      run_cycle(1'b1, 4'h0, '0, 4'h0, 4'h0, 1'b0);
      run_cycle(1'b0, 4'h7, pack4(10, 11, 12, 0), 4'h0, 4'h0, 1'b0);
      run_cycle(1'b0, 4'h0, '0, 4'hF, 4'hA, 1'b0);
      check_val("compact_rdy", 32'(obs_dec_rdy), 32'd1);
      check_val("compact_l1", 32'(lane_of(obs_ids, 1)), 32'd10);
      check_val("compact_l3", 32'(lane_of(obs_ids, 3)), 32'd11);
      check_val("compact_cnt", 32'(q_count), 32'd1);

      // Starvation: one queued, four requested
      run_cycle(1'b0, 4'h0, '0, 4'hF, 4'hF, 1'b0);
      check_val("starve_rdy", 32'(obs_dec_rdy), 32'd0);
      check_val("starve_cnt", 32'(q_count), 32'd1);

      // Cancel blocks a satisfiable grant
      run_cycle(1'b0, 4'h0, '0, 4'h1, 4'h1, 1'b1);
      check_val("cancel_rdy", 32'(obs_dec_rdy), 32'd0);
      check_val("cancel_cnt", 32'(q_count), 32'd1);
      run_cycle(1'b0, 4'h0, '0, 4'h1, 4'h1, 1'b0);
      check_val("after_cancel_id", 32'(lane_of(obs_ids, 0)), 32'd12);

      // Same-cycle forwarding on an empty queue
      run_cycle(1'b0, 4'h1, pack4(5, 0, 0, 0), 4'h1, 4'h1, 1'b0);
`ifdef TOY_PREALLOC_BYPASS_EN
      check_val("byp_rdy", 32'(obs_dec_rdy), 32'd1);
      check_val("byp_id", 32'(lane_of(obs_ids, 0)), 32'd5);
      check_val("byp_cnt", 32'(q_count), 32'd0);
`else
      check_val("nobyp_rdy", 32'(obs_dec_rdy), 32'd0);
      check_val("nobyp_cnt", 32'(q_count), 32'd1);
      run_cycle(1'b0, 4'h0, '0, 4'h1, 4'h1, 1'b0);
      check_val("nobyp_next_rdy", 32'(obs_dec_rdy), 32'd1);
      check_val("nobyp_next_id", 32'(lane_of(obs_ids, 0)), 32'd5);
`endif

      // Randomized push/pop traffic across pointer wrap with occasional cancel and reset
      for (int c = 0; c < 400; c++) begin
         logic          r_b, c_b;
         logic [N-1:0]  fv_b, dv_b, de_b;
         logic [N*W-1:0] ids_b;
         r_b  = ($urandom_range(0, 59) == 0);
         c_b  = ($urandom_range(0, 5) == 0);
         fv_b = N'($urandom_range(0, 15));
         dv_b = N'($urandom_range(0, 15));
         de_b = N'($urandom_range(0, 15));
         ids_b = pack4(seq_id, seq_id + 1, seq_id + 2, seq_id + 3);
         seq_id = (seq_id + 4) % 128;
         run_cycle(r_b, fv_b, ids_b, dv_b, de_b, c_b);
      end

      $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
      $finish;
   end

endmodule : tb_toy_prealloc_queue
